// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the crossbar configuration scheduler.
package xbar_pkg;

    localparam int DEF_SIZE = 32;

    // Port-index width for a crossbar of the given size.
    function automatic int tag_width(input int size);
        return $clog2(size);
    endfunction

    // Benes control-word width for a crossbar of the given size.
    function automatic int bit_width(input int size);
        return (2 * $clog2(size) - 1) * (size / 2);
    endfunction

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        COMMIT  = 3'd2,
        HIT     = 3'd3,
        ERR     = 3'd4,
        ACK     = 3'd5
    } state_e;

    // One destination tag per crossbar input, at the default size.
    typedef logic [$clog2(DEF_SIZE)-1:0] perm_t [DEF_SIZE];

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer;
// the pointer moves past the granted index when advance is asserted.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found_s;
    int            cand_s;

    // Search from the pointer, wrapping, for the first asserted request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int off = 0; off < N; off++) begin
            cand_s = (int'(ptr_q) + off) % N;
            if (!found_s && req[cand_s]) begin
                found_s           = 1'b1;
                grant[cand_s]     = 1'b1;
                grant_idx         = IW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer is one past the granted index, modulo N.
    always_comb begin
        if (grant_idx == IW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx + IW'(1);
        end
    end

    // Pointer register, moved only when a grant is taken.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/xbar_cfg_sched.sv
// Crossbar configuration scheduler: arbitrates permutation requests, drives
// the Benes control-bit generator, and commits control words while idle.
module xbar_cfg_sched
    import xbar_pkg::*;
#(
    parameter  int SIZE     = 32,
    parameter  int NUM_REQ  = 4,
    parameter  int GEN_LAT  = 2,
    localparam int TAGWIDTH = tag_width(SIZE),
    localparam int BITWIDTH = bit_width(SIZE),
    localparam int PW       = SIZE * TAGWIDTH,
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW       = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*PW-1:0]   req_perm,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    ack_err,
    output logic                    ack_hit,
    output logic [PW-1:0]           gen_perm,
    input  logic [BITWIDTH-1:0]     gen_ctrl,
    input  logic                    xbar_busy,
    output logic [BITWIDTH-1:0]     cfg_ctrl,
    output logic                    cfg_valid,
    output logic                    cfg_update,
    output logic                    busy
);

    // True when every value below SIZE appears exactly once in the permutation.
    function automatic logic is_bijection(input logic [PW-1:0] p);
        logic [SIZE-1:0] seen;
        seen = '0;
        for (int i = 0; i < SIZE; i++) begin
            seen = seen | (SIZE'(1) << p[i*TAGWIDTH +: TAGWIDTH]);
        end
        return &seen;
    endfunction

    state_e                state_q, state_d;
    logic [PW-1:0]         perm_q, perm_d;
    logic [NUM_REQ-1:0]    id_q, id_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BITWIDTH-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]         active_q, active_d;
    logic [PW-1:0]         gen_perm_q, gen_perm_d;
    logic [BITWIDTH-1:0]   cfg_ctrl_q, cfg_ctrl_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  cfg_update_q, cfg_update_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  ack_hit_q, ack_hit_d;
    logic                  ack_err_q, ack_err_d;

    logic                  advance_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [IW-1:0]         grant_idx_s;
    logic [PW-1:0]         slice_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .n_rst     (n_rst),
        .req       (req_valid),
        .advance   (advance_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign slice_s = req_perm[int'(grant_idx_s)*PW +: PW];

    // Next-state and register-update logic for the scheduling FSM.
    always_comb begin
        state_d      = state_q;
        perm_d       = perm_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        gen_perm_d   = gen_perm_q;
        cfg_ctrl_d   = cfg_ctrl_q;
        cfg_valid_d  = cfg_valid_q;
        cfg_update_d = 1'b0;
        ack_d        = '0;
        ack_hit_d    = 1'b0;
        ack_err_d    = 1'b0;
        advance_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    advance_s = 1'b1;
                    perm_d    = slice_s;
                    id_d      = grant_s;
                    cnt_d     = CW'(GEN_LAT - 1);
                    if (!is_bijection(slice_s)) begin
                        state_d = ERR;
                    end else if (cfg_valid_q && (slice_s == active_q)) begin
                        state_d = HIT;
                    end else begin
                        // Load the generator input at grant so it is stable for all of COMPUTE.
                        gen_perm_d = slice_s;
                        state_d    = COMPUTE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    shadow_d = gen_ctrl;
                    state_d  = COMMIT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            COMMIT: begin
                if (!xbar_busy) begin
                    cfg_ctrl_d   = shadow_q;
                    active_d     = perm_q;
                    cfg_valid_d  = 1'b1;
                    cfg_update_d = 1'b1;
                    ack_d        = id_q;
                    state_d      = ACK;
                end else begin
                    state_d = COMMIT;
                end
            end
            HIT: begin
                ack_d     = id_q;
                ack_hit_d = 1'b1;
                state_d   = ACK;
            end
            ERR: begin
                ack_d     = id_q;
                ack_err_d = 1'b1;
                state_d   = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            perm_q       <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            gen_perm_q   <= '0;
            cfg_ctrl_q   <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_update_q <= 1'b0;
            ack_q        <= '0;
            ack_hit_q    <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            perm_q       <= perm_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            gen_perm_q   <= gen_perm_d;
            cfg_ctrl_q   <= cfg_ctrl_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_update_q <= cfg_update_d;
            ack_q        <= ack_d;
            ack_hit_q    <= ack_hit_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign ack        = ack_q;
    assign ack_hit    = ack_hit_q;
    assign ack_err    = ack_err_q;
    assign gen_perm   = gen_perm_q;
    assign cfg_ctrl   = cfg_ctrl_q;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_update = cfg_update_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_xbar_cfg_sched.sv
// Scoreboard bench for xbar_cfg_sched: stimulus pushes expected acks, a
// negedge monitor pops and compares them, including the ack cycle.
module tb_xbar_cfg_sched;

    localparam int SIZE = 32;
    localparam int NR   = 4;
    localparam int GL   = 2;
    localparam int TW   = 5;
    localparam int BW   = 144;
    localparam int PW   = SIZE * TW;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [NR-1:0]    req_valid;
    logic [NR*PW-1:0] req_perm;
    logic [NR-1:0]    ack;
    logic             ack_err;
    logic             ack_hit;
    logic [PW-1:0]    gen_perm;
    logic [BW-1:0]    gen_ctrl;
    logic             xbar_busy;
    logic [BW-1:0]    cfg_ctrl;
    logic             cfg_valid;
    logic             cfg_update;
    logic             busy;

    xbar_cfg_sched #(.SIZE(SIZE), .NUM_REQ(NR), .GEN_LAT(GL)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_perm   (req_perm),
        .ack        (ack),
        .ack_err    (ack_err),
        .ack_hit    (ack_hit),
        .gen_perm   (gen_perm),
        .gen_ctrl   (gen_ctrl),
        .xbar_busy  (xbar_busy),
        .cfg_ctrl   (cfg_ctrl),
        .cfg_valid  (cfg_valid),
        .cfg_update (cfg_update),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        bit            hit;
        bit            err;
        bit            upd;
        logic [BW-1:0] ctrl;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    int            cyc     = 0;
    int            tests   = 0;
    int            fails   = 0;
    int            upd_cnt = 0;
    logic [BW-1:0] cur_cfg = '0;
    logic [PW-1:0] gen_d1  = '0;

    // Generator stand-in: output reflects gen_perm only one cycle late, so an
    // early capture would see stale data.
    function automatic logic [BW-1:0] gen_model(input logic [PW-1:0] p);
        return BW'(p) ^ BW'(p >> 16) ^ {9{16'hA5C3}};
    endfunction

    always @(posedge clk) gen_d1 <= gen_perm;
    assign gen_ctrl = gen_model(gen_d1);

    always @(posedge clk) cyc++;

    function automatic logic [PW-1:0] mk_perm(input int kind);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < SIZE; i++) begin
            case (kind)
                0:       p[i*TW +: TW] = TW'(i);
                1:       p[i*TW +: TW] = TW'(SIZE - 1 - i);
                default: p[i*TW +: TW] = TW'((i + 1) % SIZE);
            endcase
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: compare every ack against the scoreboard head, flag late acks.
    always @(negedge clk) begin
        if (n_rst) begin
            if (cfg_update) upd_cnt++;
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", PW'(ack), '0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_onehot", PW'(ack), PW'(1) << e.idx);
                    check("ack_hit", PW'(ack_hit), PW'(e.hit));
                    check("ack_err", PW'(ack_err), PW'(e.err));
                    check("ack_cfg_ctrl", PW'(cfg_ctrl), PW'(e.ctrl));
                    check("ack_cfg_valid", PW'(cfg_valid), PW'(1));
                    check("ack_cfg_update", PW'(cfg_update), PW'(e.upd));
                    check("ack_cycle", PW'(cyc), PW'(e.cyc));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                check("ack_timeout", PW'(cyc), PW'(sbq[0].cyc));
                void'(sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", PW'(busy), '0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // kind: 0 miss, 1 hit, 2 error. Request is dropped right after grant.
    task automatic issue(input int r, input logic [PW-1:0] p, input int kind,
                         input int extra, output int g);
        exp_t e;
        wait_idle();
        req_perm[r*PW +: PW] = p;
        req_valid = NR'(1) << r;
        g = cyc;
        if (kind == 0) cur_cfg = gen_model(p);
        e.idx  = r;
        e.hit  = (kind == 1);
        e.err  = (kind == 2);
        e.upd  = (kind == 0);
        e.ctrl = cur_cfg;
        e.cyc  = g + ((kind == 0) ? GL + 2 + extra : 2);
        sbq.push_back(e);
        tick();
        req_valid = '0;
    endtask

    task automatic push_exp(input int r, input int kind, input logic [PW-1:0] p, input int c);
        exp_t e;
        if (kind == 0) cur_cfg = gen_model(p);
        e.idx  = r;
        e.hit  = (kind == 1);
        e.err  = 1'b0;
        e.upd  = (kind == 0);
        e.ctrl = cur_cfg;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    initial begin
        logic [PW-1:0] id_p, rev_p, bad_p, rot_p;
        int g;
        id_p  = mk_perm(0);
        rev_p = mk_perm(1);
        rot_p = mk_perm(2);
        bad_p = id_p;
        bad_p[0 +: TW]  = 5'd5;
        bad_p[TW +: TW] = 5'd5;

        n_rst = 1'b0; req_valid = '0; req_perm = '0; xbar_busy = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();
        check("rst_ack", PW'(ack), '0);
        check("rst_flags", PW'({ack_hit, ack_err, cfg_valid, cfg_update, busy}), '0);
        check("rst_gen_perm", gen_perm, '0);
        check("rst_cfg_ctrl", PW'(cfg_ctrl), '0);

        // 1: identity miss from requester 0.
        issue(0, id_p, 0, 0, g);
        wait_idle();
        check("t1_cfg_valid", PW'(cfg_valid), PW'(1));

        // 2: same perm from requester 2 is a hit; generator input untouched.
        issue(2, id_p, 1, 0, g);
        wait_idle();
        check("t2_gen_perm", gen_perm, id_p);

        // 3: reversal while the crossbar stays busy for 10 cycles.
        xbar_busy = 1'b1;
        issue(1, rev_p, 0, 7, g);
        wait_until(g + 9);
        check("t3_hold_cfg", PW'(cfg_ctrl), PW'(gen_model(id_p)));
        check("t3_busy_wait", PW'(busy), PW'(1));
        tick();
        xbar_busy = 1'b0;
        wait_idle();

        // 4: duplicate tag rejected without waiting on a busy crossbar.
        xbar_busy = 1'b1;
        issue(3, bad_p, 2, 0, g);
        wait_idle();
        xbar_busy = 1'b0;
        check("t4_cfg_ctrl", PW'(cfg_ctrl), PW'(gen_model(rev_p)));
        check("t4_cfg_valid", PW'(cfg_valid), PW'(1));

        // 5: all requesters held: order 0,1,2,3,0, regrant right after each ack.
        wait_idle();
        req_perm = {rev_p, rev_p, id_p, id_p};
        req_valid = 4'hF;
        g = cyc;
        push_exp(0, 0, id_p,  g + 4);
        push_exp(1, 1, id_p,  g + 7);
        push_exp(2, 0, rev_p, g + 12);
        push_exp(3, 1, rev_p, g + 15);
        push_exp(0, 0, id_p,  g + 20);
        wait_until(g + 20);
        req_valid = '0;
        wait_idle();

        // 6: reset during COMPUTE aborts; pointer returns to 0.
        req_perm[PW +: PW] = rot_p;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        n_rst = 1'b0;
        #1;
        check("t6_rst_busy", PW'(busy), '0);
        check("t6_rst_cfg_valid", PW'(cfg_valid), '0);
        check("t6_rst_cfg_ctrl", PW'(cfg_ctrl), '0);
        tick();
        n_rst = 1'b1;
        cur_cfg = '0;
        tick();
        req_perm[PW +: PW]   = id_p;
        req_perm[2*PW +: PW] = rev_p;
        req_valid = 4'b0110;
        g = cyc;
        push_exp(1, 0, id_p, g + 4);
        tick();
        req_valid = '0;
        wait_idle();
        check("t6_cfg_valid", PW'(cfg_valid), PW'(1));

        repeat (5) tick();
        check("sb_drain", PW'(sbq.size()), '0);
        check("upd_count", PW'(upd_cnt), PW'(6));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
